// File: rtl/max_freq_amp_pkg.sv
// Shared widths and defaults for the spectrum peak detector.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: none; the package holds no state.
package max_freq_amp_pkg;

  localparam int BIN_W  = 11;
  localparam int AMP_W  = 10;
  localparam int FREQ_W = 13;

  localparam logic [FREQ_W-1:0] FREQ_MAX = 13'd8191;

  localparam int DEF_BIN_HZ   = 8;
  localparam int DEF_MIN_BIN  = 1;
  localparam int DEF_LAST_BIN = 511;

  // Product width wide enough that bin * bin_hz never wraps, and always
  // at least one bit wider than the output so the overflow slice exists.
  function automatic int prod_width(input int bin_hz);
    int raw;
    raw = BIN_W + $clog2(bin_hz) + 1;
    return (raw > FREQ_W) ? raw : FREQ_W + 1;
  endfunction

endpackage

// File: rtl/max_freq_amp_peak_bin_to_hz.sv
// Converts an FFT bin index to Hz (bin * BIN_HZ), saturating at FREQ_MAX.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of i_bin.
// Ports: i_bin  [BIN_W-1:0]  bin index
//        o_hz   [FREQ_W-1:0] frequency in Hz, clamped to FREQ_MAX
module bin_to_hz
  import max_freq_amp_pkg::*;
#(
  parameter int BIN_HZ = DEF_BIN_HZ
) (
  input  logic [BIN_W-1:0]  i_bin,
  output logic [FREQ_W-1:0] o_hz
);

  localparam int PROD_W = prod_width(BIN_HZ);

  logic [PROD_W-1:0] w_prod;
  logic              w_ovf;

  assign w_prod = PROD_W'(i_bin) * PROD_W'(BIN_HZ);
  assign w_ovf  = |w_prod[PROD_W-1:FREQ_W];
  assign o_hz   = w_ovf ? FREQ_MAX : w_prod[FREQ_W-1:0];

endmodule

// File: rtl/max_freq_amp_peak.sv
// Spectrum peak detector: tracks the largest amplitude across a bin sweep
// and publishes its amplitude and frequency once per sweep.
// Latency: 1 clock from the LAST_BIN sample to max_amp/max_freq.
// Backpressure: none; one sample per clock is always accepted, outputs hold
// between commits.
// Optional: define MAX_FREQ_AMP_THRESH_EN to force 0/0 output when the
// committed peak amplitude is below THRESH.
// Ports: clock, reset_n (async active-low)
//        hcount    [10:0] bin index, amplitude [9:0] magnitude of that bin
//        max_freq  [12:0] Hz of last committed peak, max_amp [9:0] its amplitude
module max_freq_amp_peak
  import max_freq_amp_pkg::*;
#(
  parameter int               MIN_BIN  = DEF_MIN_BIN,
  parameter int               LAST_BIN = DEF_LAST_BIN,
  parameter int               BIN_HZ   = DEF_BIN_HZ,
  parameter logic [AMP_W-1:0] THRESH   = 10'd32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [BIN_W-1:0]  hcount,
  input  logic [AMP_W-1:0]  amplitude,
  output logic [FREQ_W-1:0] max_freq,
  output logic [AMP_W-1:0]  max_amp
);

`ifdef MAX_FREQ_AMP_THRESH_EN
  localparam logic THRESH_EN = 1'b1;
`else
  localparam logic THRESH_EN = 1'b0;
`endif

  logic [AMP_W-1:0]  r_run_amp;
  logic [BIN_W-1:0]  r_run_bin;
  logic [AMP_W-1:0]  r_max_amp;
  logic [FREQ_W-1:0] r_max_freq;

  logic              w_in_range;
  logic              w_last;
  logic              w_gt;
  logic [AMP_W-1:0]  w_cand_amp;
  logic [BIN_W-1:0]  w_cand_bin;
  logic [FREQ_W-1:0] w_cand_hz;
  logic              w_silent;

  assign w_in_range = (hcount >= BIN_W'(MIN_BIN)) && (hcount <= BIN_W'(LAST_BIN));
  assign w_last     = (hcount == BIN_W'(LAST_BIN));

  // Strict compare: on a tie the earlier (lower) bin is kept.
  assign w_gt       = (amplitude > r_run_amp);
  assign w_cand_amp = w_gt ? amplitude : r_run_amp;
  assign w_cand_bin = w_gt ? hcount    : r_run_bin;

  bin_to_hz #(
    .BIN_HZ (BIN_HZ)
  ) u_bin_to_hz (
    .i_bin (w_cand_bin),
    .o_hz  (w_cand_hz)
  );

  assign w_silent = THRESH_EN && (w_cand_amp < THRESH);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_run_amp  <= '0;
      r_run_bin  <= '0;
      r_max_amp  <= '0;
      r_max_freq <= '0;
    end else if (w_in_range) begin
      if (w_last) begin
        // Commit the sweep, including the LAST_BIN sample itself, and
        // restart the running max for the next sweep.
        r_max_amp  <= w_silent ? '0 : w_cand_amp;
        r_max_freq <= w_silent ? '0 : w_cand_hz;
        r_run_amp  <= '0;
        r_run_bin  <= '0;
      end else if (w_gt) begin
        r_run_amp  <= amplitude;
        r_run_bin  <= hcount;
      end
    end
  end

  assign max_amp  = r_max_amp;
  assign max_freq = r_max_freq;

endmodule

// File: tb/tb_max_freq_amp_peak.sv
// Directed bench for max_freq_amp_peak: two instances (BIN_HZ=8 and 20)
// share one stimulus stream; every expected value is hand-computed.
// Latency: checks sampled 1 ns after the committing edge.
module tb_max_freq_amp_peak;

  logic        clock;
  logic        reset_n;
  logic [10:0] hcount;
  logic [9:0]  amplitude;
  logic [12:0] max_freq_a, max_freq_b;
  logic [9:0]  max_amp_a,  max_amp_b;

  int vectors;
  int miscompares;
  logic [9:0] tab [0:511];

  max_freq_amp_peak #(
    .MIN_BIN (1), .LAST_BIN (511), .BIN_HZ (8), .THRESH (10'd32)
  ) dut_a (
    .clock     (clock),
    .reset_n   (reset_n),
    .hcount    (hcount),
    .amplitude (amplitude),
    .max_freq  (max_freq_a),
    .max_amp   (max_amp_a)
  );

  max_freq_amp_peak #(
    .MIN_BIN (1), .LAST_BIN (511), .BIN_HZ (20), .THRESH (10'd32)
  ) dut_b (
    .clock     (clock),
    .reset_n   (reset_n),
    .hcount    (hcount),
    .amplitude (amplitude),
    .max_freq  (max_freq_b),
    .max_amp   (max_amp_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input int amp, input int fa, input int fb);
    chk({tag, ".amp_a"},  32'(max_amp_a),  32'(amp));
    chk({tag, ".freq_a"}, 32'(max_freq_a), 32'(fa));
    chk({tag, ".amp_b"},  32'(max_amp_b),  32'(amp));
    chk({tag, ".freq_b"}, 32'(max_freq_b), 32'(fb));
  endtask

  // Inputs change 1 ns after a rising edge and are captured on the next one.
  task automatic drive(input int h, input int a);
    hcount    = 11'(h);
    amplitude = 10'(a);
    @(posedge clock);
    #1;
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 512; i++) tab[i] = 10'(v);
  endtask

  task automatic sweep(input int lo, input int hi);
    for (int h = lo; h <= hi; h++) drive(h, int'(tab[h]));
    hcount    = 11'd0;
    amplitude = 10'd0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    hcount      = 11'd0;
    amplitude   = 10'd0;
    #1;
    chk4("reset", 0, 0, 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Single peak at bin 100.
    fill(5); tab[100] = 10'd700;
    sweep(0, 511);
    chk4("single_peak", 700, 800, 2000);

    // Outputs hold across out-of-range cycles (DC and above LAST_BIN).
    drive(0, 1023);
    drive(600, 1023);
    drive(2047, 1023);
    chk4("hold", 700, 800, 2000);

    // Tie between bins 40 and 90, DC bin ignored.
    fill(1); tab[0] = 10'd1023; tab[40] = 10'd600; tab[90] = 10'd600;
    sweep(0, 511);
    chk4("tie_dc", 600, 320, 800);

    // Peak sits on LAST_BIN itself; BIN_HZ=20 saturates 10220 to 8191.
    fill(0); tab[511] = 10'd900;
    sweep(0, 511);
    chk4("last_bin", 900, 4088, 8191);

    // Flat sweep: running max was cleared, first bin wins.
    fill(3);
    sweep(0, 511);
    chk4("flat", 3, 8, 20);

    // All zero.
    fill(0);
    sweep(0, 511);
    chk4("all_zero", 0, 0, 0);

    // Saturation boundary for BIN_HZ=20: 409*20=8180, 410*20=8200.
    fill(0); tab[409] = 10'd50;
    sweep(0, 511);
    chk4("sat_409", 50, 3272, 8180);
    fill(0); tab[410] = 10'd50;
    sweep(0, 511);
    chk4("sat_410", 50, 3280, 8191);

    // Partial sweep: no commit, but its peak carries into the next sweep.
    fill(0); tab[200] = 10'd800;
    sweep(0, 300);
    chk4("partial_hold", 50, 3280, 8191);
    fill(3);
    sweep(0, 511);
    chk4("partial_carry", 800, 1600, 4000);

    // Threshold boundary (31 below, 32 at THRESH).
    fill(0); tab[10] = 10'd31;
    sweep(0, 511);
`ifdef MAX_FREQ_AMP_THRESH_EN
    chk4("thresh_31", 0, 0, 0);
`else
    chk4("thresh_31", 31, 80, 200);
`endif
    fill(0); tab[10] = 10'd32;
    sweep(0, 511);
    chk4("thresh_32", 32, 80, 200);

    // Asynchronous reset mid-sweep: outputs clear without a clock edge and
    // the pre-reset peak at bin 50 is forgotten.
    fill(2); tab[50] = 10'd1000; tab[400] = 10'd200;
    for (int h = 0; h <= 299; h++) drive(h, int'(tab[h]));
    reset_n = 1'b0;
    #1;
    chk4("async_reset", 0, 0, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    sweep(300, 511);
    chk4("post_reset", 200, 3200, 8000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
